// File: rtl/elink_rx_align.sv
// E-link receive word aligner: bit-slip search over a 16-bit window, lock on TRAIN_PATTERN.
// Latency one clock rx_word -> data_o; no backpressure, a new word is accepted every clock.
module elink_rx_align #(
    parameter logic [7:0] TRAIN_PATTERN = 8'h5A,
    parameter int         LOCK_COUNT    = 16,
    parameter int         DWELL         = 4,
    parameter int         LOSS_COUNT    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_word,
    input  logic       serdes_lock,
    input  logic       resync,
    input  logic       train_mode,
    output logic [7:0] data_o,
    output logic       data_valid,
    output logic       locked,
    output logic [2:0] bit_offset,
    output logic [7:0] err_cnt,
    output logic [7:0] slip_cnt
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [7:0] LOCK_L  = 8'(LOCK_COUNT);
    localparam logic [3:0] DWELL_L = 4'(DWELL);
    localparam logic [3:0] LOSS_L  = 4'(LOSS_COUNT);

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [2:0] offset_q, offset_d;
    logic [7:0] err_q, err_d;
    logic [7:0] slip_q, slip_d;
    logic [3:0] dwell_q, dwell_d;
    logic [7:0] match_q, match_d;
    logic [3:0] loss_q, loss_d;

    logic [15:0] window;
    logic [7:0]  aligned;
    logic        hit;

    // Earlier bits sit in the low half, so a larger offset selects later-arriving bits.
    assign window  = {rx_word, prev_q};
    assign aligned = window[offset_q +: 8];
    assign hit     = (aligned == TRAIN_PATTERN);

    always_comb begin
        state_d  = state_q;
        prev_d   = rx_word;
        data_d   = aligned;
        valid_d  = (state_q == LOCKED);
        offset_d = offset_q;
        err_d    = err_q;
        slip_d   = slip_q;
        dwell_d  = dwell_q;
        match_d  = match_q;
        loss_d   = loss_q;

        if (!serdes_lock || resync) begin
            state_d = SEARCH;
            dwell_d = '0;
            match_d = '0;
            loss_d  = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (hit) begin
                        state_d = CHECK;
                        match_d = 8'd1;
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_L - 4'd1) begin
                        offset_d = offset_q + 3'd1;
                        dwell_d  = '0;
                        slip_d   = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
                    end else begin
                        dwell_d = dwell_q + 4'd1;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        if (match_q == LOCK_L - 8'd1) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        state_d  = SEARCH;
                        offset_d = offset_q + 3'd1;
                        slip_d   = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
                        match_d  = '0;
                        dwell_d  = '0;
                    end
                end
                LOCKED: begin
                    // Only training words can be judged; payload never disturbs lock.
                    if (train_mode && !hit) begin
                        err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        if (loss_q == LOSS_L - 4'd1) begin
                            state_d = SEARCH;
                            loss_d  = '0;
                            dwell_d = '0;
                        end else begin
                            loss_d = loss_q + 4'd1;
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            prev_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            offset_q <= '0;
            err_q    <= '0;
            slip_q   <= '0;
            dwell_q  <= '0;
            match_q  <= '0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            offset_q <= offset_d;
            err_q    <= err_d;
            slip_q   <= slip_d;
            dwell_q  <= dwell_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
        end
    end

    assign data_o     = data_q;
    assign data_valid = valid_q;
    assign locked     = (state_q == LOCKED);
    assign bit_offset = offset_q;
    assign err_cnt    = err_q;
    assign slip_cnt   = slip_q;

endmodule

// File: tb/tb_elink_rx_align.sv
// Bench for elink_rx_align: serial-stream stimulus with a bit delay, checked each cycle against a behavioural model.
module tb_elink_rx_align;

    localparam logic [7:0] TP = 8'h5A;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_word = 8'h00;
    logic       serdes_lock = 1'b1;
    logic       resync = 1'b0;
    logic       train_mode = 1'b1;
    logic [7:0] data_o;
    logic       data_valid;
    logic       locked;
    logic [2:0] bit_offset;
    logic [7:0] err_cnt;
    logic [7:0] slip_cnt;

    bit clk_en = 1'b1;
    bit cmp_en = 1'b1;
    int checks = 0;
    int errors = 0;
    bit q[$];

    elink_rx_align dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_word    (rx_word),
        .serdes_lock(serdes_lock),
        .resync     (resync),
        .train_mode (train_mode),
        .data_o     (data_o),
        .data_valid (data_valid),
        .locked     (locked),
        .bit_offset (bit_offset),
        .err_cnt    (err_cnt),
        .slip_cnt   (slip_cnt)
    );

    always begin
        #10;
        if (clk_en) clock = ~clock;
    end

    // Behavioural model: mode 0 = searching, 1 = confirming, 2 = locked.
    int          m_mode, m_off, m_dwell, m_match, m_loss, m_err, m_slip;
    logic [7:0]  m_prev, m_data, m_al;
    logic        m_valid;
    logic [15:0] m_win;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_off = 0; m_dwell = 0; m_match = 0; m_loss = 0;
            m_err = 0; m_slip = 0; m_prev = 8'h00; m_data = 8'h00; m_valid = 1'b0;
        end else begin
            m_win   = {rx_word, m_prev};
            m_al    = 8'(m_win >> m_off);
            m_data  = m_al;
            m_valid = (m_mode == 2);
            m_prev  = rx_word;
            if (!serdes_lock || resync) begin
                m_mode = 0; m_dwell = 0; m_match = 0; m_loss = 0;
            end else if (m_mode == 0) begin
                if (m_al == TP) begin
                    m_mode = 1; m_match = 1; m_dwell = 0;
                end else begin
                    m_dwell++;
                    if (m_dwell == 4) begin
                        m_off = (m_off + 1) % 8; m_dwell = 0;
                        m_slip = (m_slip < 255) ? m_slip + 1 : 255;
                    end
                end
            end else if (m_mode == 1) begin
                if (m_al == TP) begin
                    m_match++;
                    if (m_match == 16) begin m_mode = 2; m_match = 0; end
                end else begin
                    m_mode = 0; m_off = (m_off + 1) % 8; m_match = 0; m_dwell = 0;
                    m_slip = (m_slip < 255) ? m_slip + 1 : 255;
                end
            end else begin
                if (train_mode && m_al != TP) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_loss++;
                    if (m_loss == 4) begin m_mode = 0; m_loss = 0; m_dwell = 0; end
                end else begin
                    m_loss = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && cmp_en) begin
            checks++;
            if (data_o !== m_data || data_valid !== m_valid || locked !== (m_mode == 2) ||
                int'(bit_offset) != m_off || int'(err_cnt) != m_err || int'(slip_cnt) != m_slip) begin
                errors++;
                $display("FAIL model_cycle t=%0t actual d=%h v=%b l=%b off=%0d err=%0d slip=%0d required d=%h v=%b l=%b off=%0d err=%0d slip=%0d",
                         $time, data_o, data_valid, locked, bit_offset, err_cnt, slip_cnt,
                         m_data, m_valid, (m_mode == 2), m_off, m_err, m_slip);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // One byte from the far end enters the serial line; one received word leaves it.
    task automatic send(input logic [7:0] b);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
        for (int i = 0; i < 8; i++) w[i] = q.pop_front();
        rx_word = w;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int d);
        reset_n = 1'b0;
        serdes_lock = 1'b1; resync = 1'b0; train_mode = 1'b1;
        q.delete();
        for (int i = 0; i < d; i++) q.push_back(1'b0);
        rx_word = 8'h00;
        #1;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_lock();
        int n = 0;
        while (!locked && n < 200) begin send(TP); n++; end
        chk("lock_reached", int'(locked), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int slip_b, err_b, saw_lock;
        logic [7:0] b, last_b;

        // Reset values
        reset_n = 1'b0;
        #1;
        chk("reset_data_o", int'(data_o), 0);
        chk("reset_valid", int'(data_valid), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_slip", int'(slip_cnt), 0);

        // Training stream delayed by 3 bits
        do_reset(3);
        repeat (12) send(TP);
        chk("d3_offset_after12", int'(bit_offset), 3);
        chk("d3_slip_after12", int'(slip_cnt), 3);
        repeat (15) send(TP);
        chk("d3_not_locked_15", int'(locked), 0);
        send(TP);
        chk("d3_locked_16", int'(locked), 1);
        chk("d3_valid_lag", int'(data_valid), 0);
        send(TP);
        chk("d3_data_o", int'(data_o), 8'h5A);
        chk("d3_data_valid", int'(data_valid), 1);

        // Loss of lock at offset 5
        do_reset(5);
        wait_lock();
        chk("d5_offset", int'(bit_offset), 5);
        slip_b = slip_cnt;
        repeat (3) send(8'hFF);
        repeat (2) send(TP);
        chk("d5_err3", int'(err_cnt), 3);
        chk("d5_still_locked", int'(locked), 1);
        repeat (4) send(8'hFF);
        chk("d5_locked_before_4th", int'(locked), 1);
        send(TP);
        chk("d5_unlocked", int'(locked), 0);
        chk("d5_offset_kept", int'(bit_offset), 5);
        chk("d5_err7", int'(err_cnt), 7);
        wait_lock();
        chk("d5_relock_no_slip", int'(slip_cnt), slip_b);

        // Payload with training off
        train_mode = 1'b0;
        err_b = err_cnt;
        last_b = TP;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            send(b);
            if (i > 0) begin
                chk("payload_data", int'(data_o), int'(last_b));
                chk("payload_valid", int'(data_valid), 1);
            end
            last_b = b;
        end
        chk("payload_err_same", int'(err_cnt), err_b);

        // Resync and serdes_lock drop
        train_mode = 1'b1;
        repeat (3) send(TP);
        slip_b = slip_cnt;
        resync = 1'b1;
        send(TP);
        resync = 1'b0;
        chk("resync_unlock", int'(locked), 0);
        repeat (15) send(TP);
        chk("resync_not_yet", int'(locked), 0);
        send(TP);
        chk("resync_relock", int'(locked), 1);
        serdes_lock = 1'b0;
        send(TP);
        chk("sl_unlock", int'(locked), 0);
        repeat (9) send(8'h00);
        chk("sl_no_slips", int'(slip_cnt), slip_b);
        serdes_lock = 1'b1;
        send(TP);
        repeat (16) send(TP);
        chk("sl_relock", int'(locked), 1);
        chk("sl_offset", int'(bit_offset), 5);

        // All-zeros: offset wraps, slip saturates
        do_reset(0);
        saw_lock = 0;
        for (int i = 1; i <= 2100; i++) begin
            send(8'h00);
            if (locked) saw_lock = 1;
            chk("zeros_offset", int'(bit_offset), (i / 4) % 8);
        end
        chk("zeros_slip_sat", int'(slip_cnt), 255);
        chk("zeros_never_locked", saw_lock, 0);

        // Randomised mix with occasional delay shifts
        do_reset($urandom_range(0, 7));
        for (int i = 0; i < 3000; i++) begin
            serdes_lock = ($urandom_range(0, 49) != 0);
            resync      = ($urandom_range(0, 79) == 0);
            train_mode  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) q.push_back(1'b0);
            send(($urandom_range(0, 7) == 0) ? 8'($urandom) : TP);
        end
        serdes_lock = 1'b1; resync = 1'b0; train_mode = 1'b1;

        // Reset mid-CHECK with the clock stopped
        do_reset(2);
        repeat (10) send(TP);
        chk("chk_state_slip", int'(slip_cnt), 2);
        chk("chk_state_unlocked", int'(locked), 0);
        @(negedge clock);
        clk_en = 1'b0;
        cmp_en = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_data_o", int'(data_o), 0);
        chk("async_valid", int'(data_valid), 0);
        chk("async_locked", int'(locked), 0);
        chk("async_offset", int'(bit_offset), 0);
        chk("async_err", int'(err_cnt), 0);
        chk("async_slip", int'(slip_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elink_rx_align.md
ELINK_RX_ALIGN -- requirements
Module: elink_rx_align

Interface
REQ-001 Parameter TRAIN_PATTERN, default 8'h5A, e-link training/idle word (no rotation of it equals itself).
REQ-002 Parameter LOCK_COUNT, default 16, consecutive pattern matches required to declare lock (2..255).
REQ-003 Parameter DWELL, default 4, mismatching cycles spent at one bit offset before advancing (1..15).
REQ-004 Parameter LOSS_COUNT, default 4, consecutive training mismatches while locked that force re-search (1..15).
REQ-005 clock  input  1  40 MHz frame clock; the same clock that drives the ISERDES CLKDIV; all logic on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-007 rx_word  input  8  parallel word from 1:8 ISERDES, new word every clock, bit 0 received first.
REQ-008 serdes_lock  input  1  BUFPLL/PLL lock; low forces search.
REQ-009 resync  input  1  single-cycle request to discard lock and re-search.
REQ-010 train_mode  input  1  high while far end transmits TRAIN_PATTERN continuously.
REQ-011 data_o  output  8  bit-aligned received word.
REQ-012 data_valid  output  1  data_o is aligned payload.
REQ-013 locked  output  1  alignment FSM in LOCKED.
REQ-014 bit_offset  output  3  current alignment offset.
REQ-015 err_cnt  output  8  saturating count of training mismatches while locked.
REQ-016 slip_cnt  output  8  saturating count of offset advances.

Function
REQ-017 Window: register previous rx_word as prev; window[15:0] = {rx_word, prev}; aligned = window[bit_offset+7 : bit_offset].
REQ-018 data_o SHALL be aligned registered: one clock latency from rx_word to data_o; data_o updates every cycle in all states.
REQ-019 data_valid SHALL equal locked registered in the same cycle as data_o (both reflect state of the cycle aligned was sampled).
REQ-020 FSM states SEARCH, CHECK, LOCKED; reset state SEARCH.
REQ-021 SEARCH: aligned == TRAIN_PATTERN -> CHECK with match count 1; else dwell counter increments; on reaching DWELL, bit_offset <= bit_offset+1 (7 wraps to 0), dwell counter cleared, slip_cnt +1.
REQ-022 CHECK: each match increments match count; count reaching LOCK_COUNT -> LOCKED; any mismatch -> SEARCH with bit_offset+1, slip_cnt +1, counters cleared.
REQ-023 LOCKED: bit_offset frozen; if train_mode high and aligned != TRAIN_PATTERN, err_cnt +1 and loss counter +1; a match or train_mode low clears loss counter; loss counter reaching LOSS_COUNT -> SEARCH (offset unchanged, dwell cleared).
REQ-024 err_cnt and slip_cnt SHALL saturate at 255 and never wrap; cleared only by reset.
REQ-025 serdes_lock low in any state: next state SEARCH, match/dwell/loss counters cleared, bit_offset held; FSM stays in SEARCH (no counting, no slips) while serdes_lock low.
REQ-026 resync high: next state SEARCH, counters cleared, bit_offset held; resync takes priority over any same-cycle transition; serdes_lock low has priority over resync (identical effect).
REQ-027 Match reaching LOCK_COUNT in the same cycle as resync: resync wins, state SEARCH.
REQ-028 Dwell/match/loss counters sized to hold their maximum parameter value without overflow.

Reset
REQ-029 reset_n low asynchronously sets: state SEARCH, bit_offset 0, prev 0, data_o 8'h00, data_valid 0, locked 0, err_cnt 0, slip_cnt 0, all internal counters 0.
REQ-030 Release of reset_n is synchronous to clock by the integrating level; block begins SEARCH on first clock edge after release.
REQ-031 Reset asserted mid-CHECK or LOCKED aborts immediately; outputs reach reset values without a clock edge.

Verification
REQ-032 Serial stream of 8'h5A delayed by 3 bits, serdes_lock=1 -> bit_offset reaches 3 after 12 mismatch cycles (slip_cnt=3), locked=1 exactly LOCK_COUNT=16 matches after first match, data_o=8'h5A with data_valid=1.
REQ-033 Locked at offset 5, train_mode=1, inject 3 corrupt words then correct -> err_cnt=3, locked stays 1; inject 4 consecutive corrupt -> locked=0 in cycle after 4th, bit_offset still 5.
REQ-034 Locked, train_mode=0, random payload with delay 5 -> data_o equals payload byte one clock after its last bit lands, data_valid=1 throughout, err_cnt unchanged.
REQ-035 Pulse resync while locked, and separately drop serdes_lock for 10 cycles -> locked=0 next cycle, no slips during serdes_lock low, relock at same offset after 16 matches.
REQ-036 Feed all-zeros for 2100 cycles -> bit_offset cycles 0..7 wrapping, slip_cnt saturates at 255, locked never asserts.
REQ-037 Assert reset_n low mid-CHECK with no clock running -> all outputs at REQ-029 values immediately.
